// File: rtl/cordic_fix2fp_if.sv
// Start/done handshake bundle between the CORDIC x-output and the fix-to-float converter.
interface cordic_fix2fp_if #(
    parameter int unsigned WIDTH = 21
);
    logic             start;
    logic [WIDTH-1:0] dataa;
    logic             busy;
    logic             done;
    logic [31:0]      result;

    modport master (output start, output dataa, input busy, input done, input result);
    modport slave  (input start, input dataa, output busy, output done, output result);
endinterface

// File: rtl/cordic_fix2fp_seq.sv
// Multi-cycle Q1.(WIDTH-1) two's-complement to IEEE-754 single converter.
// Define F2F_CLZ_EN for a single-cycle priority-encoder normaliser instead of the bit-serial one.
module cordic_fix2fp_seq #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned BIAS  = 127
) (
    input  logic            clock,
    input  logic            aclr,
    input  logic            clk_en,
    cordic_fix2fp_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StNorm, StPack} state_e;

    state_e           state_q, state_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [7:0]       exp_q, exp_d;
    logic [31:0]      result_q, result_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] dataa_abs;
    logic [22:0]      mant;

    // The most negative input negates to itself, which is exactly the correct magnitude.
    assign dataa_abs = bus.dataa[WIDTH-1] ? (~bus.dataa + WIDTH'(1)) : bus.dataa;
    // Hidden bit dropped; remaining fraction bits are left-aligned in the significand.
    assign mant      = 23'(mag_q[WIDTH-2:0]) << (24 - WIDTH);

`ifdef F2F_CLZ_EN
    localparam int unsigned LzW = $clog2(WIDTH);
    logic [LzW-1:0] lz;

    always_comb begin
        lz = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mag_q[i]) lz = LzW'(WIDTH - 1 - i);
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sign_d  = bus.dataa[WIDTH-1];
                    mag_d   = dataa_abs;
                    exp_d   = 8'(BIAS);
                    state_d = (dataa_abs == '0) ? StPack : StNorm;
                end
            end
            StNorm: begin
`ifdef F2F_CLZ_EN
                mag_d   = mag_q << lz;
                exp_d   = 8'(BIAS) - 8'(lz);
                state_d = StPack;
`else
                if (mag_q[WIDTH-1]) begin
                    state_d = StPack;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 8'd1;
                end
`endif
            end
            StPack: begin
                result_d = (mag_q == '0) ? 32'h0 : {sign_q, exp_q, mant};
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            exp_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_cordic_fix2fp_seq.sv
// Randomised self-checking bench for cordic_fix2fp_seq against a real-arithmetic reference.
module tb_cordic_fix2fp_seq;

    logic clock = 1'b0;
    logic aclr;
    logic clk_en;

    always #5 clock = ~clock;

    cordic_fix2fp_if #(.WIDTH(21)) bus ();

    cordic_fix2fp_seq #(.WIDTH(21), .BIAS(127)) dut (
        .clock  (clock),
        .aclr   (aclr),
        .clk_en (clk_en),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Value-level reference: scale into [1,2) by doubling, read off exponent and fraction.
    function automatic logic [31:0] ref_result(input logic [20:0] d);
        int   v;
        int   e;
        int   frac;
        real  r;
        logic s;
        v = $signed({{11{d[20]}}, d});
        s = (v < 0);
        if (v == 0) return 32'h0;
        r = (s ? -v : v) / 1048576.0;
        e = 127;
        while (r < 1.0) begin
            r = r * 2.0;
            e--;
        end
        frac = int'((r - 1.0) * 8388608.0);
        return {s, 8'(e), 23'(frac)};
    endfunction

    function automatic int ref_lat(input logic [20:0] d);
        int  v;
        int  k;
        real r;
        v = $signed({{11{d[20]}}, d});
        if (v == 0) return 1;
`ifdef F2F_CLZ_EN
        return 2;
`else
        r = ((v < 0) ? -v : v) / 1048576.0;
        k = 0;
        while (r < 1.0) begin
            r = r * 2.0;
            k++;
        end
        return k + 2;
`endif
    endfunction

    task automatic start_conv(input logic [20:0] d);
        @(negedge clock);
        bus.start = 1'b1;
        bus.dataa = d;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; -1 on timeout.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clock);
            #1;
            lat++;
            if (bus.done) return;
            if (!bus.busy) busy_ok = 1'b0;
        end
        lat = -1;
    endtask

    task automatic run_one(input string tag, input logic [20:0] d);
        int   lat;
        logic bok;
        start_conv(d);
        wait_done(lat, bok);
        check({tag, "_result"}, bus.result, ref_result(d));
        check({tag, "_latency"}, 32'(lat), 32'(ref_lat(d)));
        check({tag, "_busy"}, 32'(bok), 32'd1);
    endtask

    logic [20:0] dir_vec [6] = '{21'h080000, 21'h100000, 21'h180000,
                                 21'h000001, 21'h0C90FE, 21'h000000};
    logic [31:0] dir_exp [6] = '{32'h3F000000, 32'hBF800000, 32'hBF000000,
                                 32'h35800000, 32'h3F490FE0, 32'h00000000};

    initial begin
        int          lat;
        int          l2;
        int          stray;
        logic        bok;
        logic [20:0] d;

        aclr      = 1'b1;
        clk_en    = 1'b1;
        bus.start = 1'b0;
        bus.dataa = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'h0);
        aclr = 1'b0;

        // Directed vectors against hand-computed words plus the model's latency
        for (int i = 0; i < 6; i++) begin
            start_conv(dir_vec[i]);
            wait_done(lat, bok);
            check($sformatf("dir%0d_result", i), bus.result, dir_exp[i]);
            check($sformatf("dir%0d_latency", i), 32'(lat), 32'(ref_lat(dir_vec[i])));
            check($sformatf("dir%0d_busy", i), 32'(bok), 32'd1);
            repeat (2) @(posedge clock);
        end

        for (int i = 0; i < 40; i++) begin
            d = 21'($urandom) >> $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) d = -d;
            run_one($sformatf("rnd%0d", i), d);
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end

        // Start while busy must be ignored
        start_conv(21'h000001);
        lat = 0;
`ifndef F2F_CLZ_EN
        repeat (4) begin
            @(posedge clock);
            #1;
            lat++;
        end
`endif
        start_conv(21'h080000);
        lat++;
        wait_done(l2, bok);
        check("busy_start_result", bus.result, 32'h35800000);
        check("busy_start_latency", 32'(lat + l2), 32'(ref_lat(21'h000001)));

        // Back-to-back: start is presented during the done cycle
        check("b2b_done_cycle", 32'(bus.done), 32'd1);
        start_conv(21'h080000);
        wait_done(lat, bok);
        check("b2b_result", bus.result, 32'h3F000000);
        check("b2b_latency", 32'(lat), 32'(ref_lat(21'h080000)));

        // Done must hold while disabled
        clk_en = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("hold_done", 32'(bus.done), 32'd1);
        clk_en = 1'b1;
        @(posedge clock);
        #1;
        check("done_clear", 32'(bus.done), 32'd0);

        // Enable stall mid-conversion stretches latency exactly
        start_conv(21'h000001);
        clk_en = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("stall_busy", 32'(bus.busy), 32'd1);
        clk_en = 1'b1;
        wait_done(lat, bok);
        check("stall_result", bus.result, 32'h35800000);
        check("stall_latency", 32'(lat + 4), 32'(ref_lat(21'h000001) + 4));
        repeat (2) @(posedge clock);

        // Reset abandons a conversion
        start_conv(21'h000001);
        aclr = 1'b1;
        @(posedge clock);
        #1;
        aclr = 1'b0;
        check("aclr_busy", 32'(bus.busy), 32'd0);
        check("aclr_done", 32'(bus.done), 32'd0);
        check("aclr_result", bus.result, 32'h0);
        stray = 0;
        repeat (30) begin
            @(posedge clock);
            #1;
            if (bus.done) stray++;
        end
        check("aclr_stray_done", 32'(stray), 32'd0);
        run_one("post_aclr", 21'h0C90FE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cordic_fix2fp_seq.md
Name: cordic_fix2fp_seq

Overview:
- Downstream stage of the CORDIC cosine pipeline; replaces the combinational fixed-to-float packer on the x output.
- Takes a 21-bit signed Q1.20 cosine result and produces an IEEE-754 single-precision word.
- Converts via a multi-cycle normaliser with a start/done handshake, so the wide leading-zero shifter leaves the critical path.
- Sits between the CORDIC stage-2 output and the custom-instruction result mux.

Parameters:
- WIDTH, 21: fixed-point input width, two's complement, 1 integer bit + (WIDTH-1) fraction bits.
- BIAS, 127: float exponent bias.

Ports:
- clock  in  1  system clock, rising edge.
- aclr  in  1  reset, synchronous, active-high (name kept per codebase; it is NOT asynchronous).
- clk_en  in  1  global enable; when low, all state holds.
- start  in  1  request pulse; sampled only in IDLE with clk_en=1.
- dataa  in  WIDTH  Q1.20 operand; sampled on the accepted start edge.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; result is valid from the same cycle.
- result  out  32  IEEE-754 single; holds until the next done.

Behaviour:
- Reset (aclr=1 at a clock edge, regardless of clk_en): state=IDLE, result=0x00000000, done=0, busy=0. A conversion in progress is abandoned and no done is produced.
- All register updates require clk_en=1, except reset. With clk_en=0, state/result/done hold, including a high done.
- States: IDLE, NORM, PACK.
- IDLE: on start, latch sign=dataa[20] and mag=|dataa| as WIDTH-bit unsigned. |-1.0|=0x100000 fits with no overflow. Set exp=BIAS.
  - If mag==0, go to PACK; otherwise go to NORM.
  - done is cleared on every enabled edge not entering a done cycle.
- NORM, per enabled edge:
  - If mag[20]=1, go to PACK.
  - Else mag<=mag<<1 and exp<=exp-1.
  - At most 20 shifts; exp minimum is 107.
- PACK: result<={sign, exp[7:0], mag[19:0], 3'b000}; done<=1; go to IDLE.
  - Zero input gives result=0x00000000, including a sign of 0.
- No rounding: 21 significant bits always fit the 24-bit significand, so conversion is exact.
- Latency, from the accepted start edge to the done cycle (k = leading zeros of mag within bit 20..0):
  - non-zero input: k+2 cycles;
  - zero input: 1 cycle.
- start while busy=1 is ignored; no queueing.
- start during the done cycle is accepted, since state is already IDLE, giving back-to-back operation.
- No denormals or infinities are reachable; exponent range is 107..127.

Optional Feature:
- Macro: F2F_CLZ_EN.
- Defined: NORM completes in one cycle.
  - A combinational priority encoder computes lz (0..20).
  - mag<=mag<<lz, exp<=BIAS-lz, then go to PACK.
  - Fixed latency: 2 cycles for non-zero input, 1 for zero.
- Undefined: the iterative single-bit shifter above, with variable latency k+2.
- Results are bit-identical in both builds.

Test Plan:
- dataa=0x080000 (0.5), start pulse:
  - result=0x3F000000, done 3 cycles after start;
  - 2 cycles if F2F_CLZ_EN.
- dataa=0x100000 (-1.0): result=0xBF800000, latency 2. dataa=0x180000 (-0.5): result=0xBF000000, latency 3.
- dataa=0x000001 (2^-20): result=0x35800000, latency 22 (2 if F2F_CLZ_EN); busy high for the whole conversion.
- dataa=0x0C90FE (pi/4 from CORDIC): result=0x3F490FE0. dataa=0 gives result=0x00000000 with latency 1.
- Handshake and enable:
  - start at 0x000001 with a second start (0x080000) 5 cycles later: second start ignored, result 0x35800000.
  - Then start on the done cycle: accepted, next result 0x3F000000.
  - clk_en low for 4 cycles mid-NORM stretches latency by exactly 4.
- aclr asserted mid-NORM: next cycle busy=0, done=0, result=0x00000000, no stray done; a new start then converts normally.
